// File: rtl/layer_conf_sequencer.sv
// Steps the accelerator core through a table of per-layer configuration
// descriptors, handshaking on the core's done status between layers.
module layer_conf_sequencer #(
    parameter int MAX_LAYERS = 8,
    parameter int REG_WIDTH  = 32,
    parameter int SETTLE_CYC = 2,
    parameter int TIMEOUT_W  = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          desc_wr_en,
    input  logic [$clog2(MAX_LAYERS)-1:0] desc_wr_layer,
    input  logic [2:0]                    desc_wr_field,
    input  logic [REG_WIDTH-1:0]          desc_wr_data,
    input  logic                          i_start,
    input  logic [$clog2(MAX_LAYERS):0]   i_num_layers,
    input  logic                          i_abort,
    input  logic [REG_WIDTH-1:0]          i_conf_status,
    output logic [REG_WIDTH-1:0]          o_conf_ctrl,
    output logic [REG_WIDTH-1:0]          o_conf_outputsize,
    output logic [REG_WIDTH-1:0]          o_conf_kernelsize,
    output logic [REG_WIDTH-1:0]          o_conf_weightinterval,
    output logic [REG_WIDTH-1:0]          o_conf_kernelshape,
    output logic [REG_WIDTH-1:0]          o_conf_inputshape,
    output logic [REG_WIDTH-1:0]          o_conf_inputrstcnt,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_err,
    output logic [$clog2(MAX_LAYERS)-1:0] o_layer_idx
);

    localparam int IDX_W = $clog2(MAX_LAYERS);
    localparam int NL_W  = IDX_W + 1;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0]     SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [TIMEOUT_W-1:0] WD_LAST     = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_DRAIN,
        S_FIN
    } state_t;

    // The enable bit belongs to the sequencer, so flag bit 0 is never stored.
    logic [REG_WIDTH-1:0] tab_outputsize     [MAX_LAYERS];
    logic [REG_WIDTH-1:0] tab_kernelsize     [MAX_LAYERS];
    logic [REG_WIDTH-1:0] tab_weightinterval [MAX_LAYERS];
    logic [REG_WIDTH-1:0] tab_kernelshape    [MAX_LAYERS];
    logic [REG_WIDTH-1:0] tab_inputshape     [MAX_LAYERS];
    logic [REG_WIDTH-1:0] tab_inputrstcnt    [MAX_LAYERS];
    logic [REG_WIDTH-1:1] tab_flags          [MAX_LAYERS];

    state_t               state;
    logic [NL_W-1:0]      num_layers;
    logic [SET_W-1:0]     settle_cnt;
    logic [TIMEOUT_W-1:0] watchdog;

    logic core_done;
    logic start_ok;
    logic last_layer;
    logic unused_status;

    assign core_done     = i_conf_status[1];
    assign start_ok      = (i_num_layers != '0) && (i_num_layers <= NL_W'(MAX_LAYERS));
    assign last_layer    = ({1'b0, o_layer_idx} == (num_layers - NL_W'(1)));
    assign unused_status = ^{i_conf_status[REG_WIDTH-1:2], i_conf_status[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_LAYERS; i++) begin
                tab_outputsize[i]     <= '0;
                tab_kernelsize[i]     <= '0;
                tab_weightinterval[i] <= '0;
                tab_kernelshape[i]    <= '0;
                tab_inputshape[i]     <= '0;
                tab_inputrstcnt[i]    <= '0;
                tab_flags[i]          <= '0;
            end
        end else if (desc_wr_en && (state == S_IDLE)) begin
            case (desc_wr_field)
                3'd0:    tab_outputsize[desc_wr_layer]     <= desc_wr_data;
                3'd1:    tab_kernelsize[desc_wr_layer]     <= desc_wr_data;
                3'd2:    tab_weightinterval[desc_wr_layer] <= desc_wr_data;
                3'd3:    tab_kernelshape[desc_wr_layer]    <= desc_wr_data;
                3'd4:    tab_inputshape[desc_wr_layer]     <= desc_wr_data;
                3'd5:    tab_inputrstcnt[desc_wr_layer]    <= desc_wr_data;
                3'd6:    tab_flags[desc_wr_layer]          <= desc_wr_data[REG_WIDTH-1:1];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= S_IDLE;
            num_layers            <= '0;
            settle_cnt            <= '0;
            watchdog              <= '0;
            o_conf_ctrl           <= '0;
            o_conf_outputsize     <= '0;
            o_conf_kernelsize     <= '0;
            o_conf_weightinterval <= '0;
            o_conf_kernelshape    <= '0;
            o_conf_inputshape     <= '0;
            o_conf_inputrstcnt    <= '0;
            o_busy                <= 1'b0;
            o_done                <= 1'b0;
            o_err                 <= 1'b0;
            o_layer_idx           <= '0;
        end else begin
            o_done <= 1'b0;
            // Abort wins over every other transition and never flags an error.
            if (i_abort && (state != S_IDLE)) begin
                state       <= S_IDLE;
                o_conf_ctrl <= '0;
                o_busy      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        o_conf_ctrl <= '0;
                        if (i_start) begin
                            if (start_ok) begin
                                num_layers  <= i_num_layers;
                                o_layer_idx <= '0;
                                o_err       <= 1'b0;
                                o_busy      <= 1'b1;
                                state       <= S_LOAD;
                            end else begin
                                o_err <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        o_conf_outputsize     <= tab_outputsize[o_layer_idx];
                        o_conf_kernelsize     <= tab_kernelsize[o_layer_idx];
                        o_conf_weightinterval <= tab_weightinterval[o_layer_idx];
                        o_conf_kernelshape    <= tab_kernelshape[o_layer_idx];
                        o_conf_inputshape     <= tab_inputshape[o_layer_idx];
                        o_conf_inputrstcnt    <= tab_inputrstcnt[o_layer_idx];
                        o_conf_ctrl           <= {tab_flags[o_layer_idx], 1'b0};
                        settle_cnt            <= '0;
                        state                 <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            o_conf_ctrl[0] <= 1'b1;
                            watchdog       <= '0;
                            state          <= S_RUN;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    // The watchdog fires on the cycle its count would reach all-ones.
                    S_RUN: begin
                        if (core_done) begin
                            o_conf_ctrl[0] <= 1'b0;
                            state          <= S_DRAIN;
                        end else if (watchdog == WD_LAST) begin
                            o_err       <= 1'b1;
                            o_conf_ctrl <= '0;
                            o_busy      <= 1'b0;
                            state       <= S_IDLE;
                        end else begin
                            watchdog <= watchdog + 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (!core_done) begin
                            if (last_layer) begin
                                o_done <= 1'b1;
                                state  <= S_FIN;
                            end else begin
                                o_layer_idx <= o_layer_idx + 1'b1;
                                state       <= S_LOAD;
                            end
                        end
                    end
                    S_FIN: begin
                        o_busy <= 1'b0;
                        state  <= S_IDLE;
                    end
                    default: begin
                        o_conf_ctrl <= '0;
                        o_busy      <= 1'b0;
                        state       <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
